// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. It drives one external combinational full-adder
// cell one bit per clock, LSB first, and collects the sum and final carry.
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             fa_i0,
    output logic             fa_i1,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sh_a_reg, sh_b_reg, res_reg, sum_reg;
    logic               carry_reg, co_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [WIDTH-1:0]   b_load;
    logic               last_bit;
    logic               accept;

    // Subtraction is A + ~B + 1: B is inverted at load and the carry flop is seeded with 1.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_load[gi] = in_b[gi] ^ in_sub;
        end
    endgenerate

    assign last_bit = (count_reg == CNT_W'(WIDTH - 1));
    assign accept   = in_valid && in_ready;
    assign out_sum  = sum_reg;
    assign out_co   = co_reg;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        fa_i0      = 1'b0;
        fa_i1      = 1'b0;
        fa_ci      = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                fa_i0 = sh_a_reg[0];
                fa_i1 = sh_b_reg[0];
                fa_ci = carry_reg;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // fa_s/fa_co are only looked at in RUN, so unknowns on them elsewhere never reach a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_reg  <= '0;
            sh_b_reg  <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sh_a_reg  <= in_a;
                        sh_b_reg  <= b_load;
                        carry_reg <= in_sub;
                        count_reg <= '0;
                    end
                end
                RUN: begin
                    sh_a_reg  <= sh_a_reg >> 1;
                    sh_b_reg  <= sh_b_reg >> 1;
                    res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
                    carry_reg <= fa_co;
                    count_reg <= count_reg + CNT_W'(1);
                    // Published result changes only on the final bit of the next command.
                    if (last_bit) begin
                        sum_reg <= {fa_s, res_reg[WIDTH-1:1]};
                        co_reg  <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a behavioural full-adder cell, directed cases, then random
// add/sub traffic with random result-side stalls checked against plain arithmetic.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_sub;
    logic         fa_i0, fa_i1, fa_ci;
    logic         fa_s, fa_co;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .fa_i0     (fa_i0),
        .fa_i1     (fa_i1),
        .fa_ci     (fa_ci),
        .fa_s      (fa_s),
        .fa_co     (fa_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .busy      (busy)
    );

    // The external full-adder cell under exercise.
    assign fa_s  = fa_i0 ^ fa_i1 ^ fa_ci;
    assign fa_co = (fa_i0 & fa_i1) | (fa_i0 & fa_ci) | (fa_i1 & fa_ci);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_fa"},        {fa_i0, fa_i1, fa_ci}, 0);
    endtask

    // Issue a command from IDLE; returns after the accept edge, sampled at the following negedge.
    task automatic accept_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_sub   = 1'($urandom);
    endtask

    // Full transaction: per-bit adder-port checks, exact latency, stalled DONE, release.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int stall, input bit junk);
        int unsigned bp, mask, cin, exp_sum, exp_co;
        logic [W-1:0] held;
        bp = sub ? (~32'(b) & 32'hFF) : 32'(b);
        if (sub) begin
            exp_sum = (32'(a) - 32'(b)) & 32'hFF;
            exp_co  = (a >= b) ? 1 : 0;
        end else begin
            exp_sum = (32'(a) + 32'(b)) & 32'hFF;
            exp_co  = ((32'(a) + 32'(b)) >> 8) & 1;
        end
        out_ready = 1'b0;
        accept_cmd(a, b, sub);
        for (int i = 0; i < W; i++) begin
            mask = (32'd1 << i) - 1;
            cin  = (((32'(a) & mask) + (bp & mask) + 32'(sub)) >> i) & 1;
            check("run_fa_i0", fa_i0, (32'(a) >> i) & 1);
            check("run_fa_i1", fa_i1, (bp >> i) & 1);
            check("run_fa_ci", fa_ci, cin);
            check("run_status", {out_valid, in_ready, busy}, 3'b001);
            @(posedge clk);
            @(negedge clk);
        end
        check("done_valid", out_valid, 1);
        check("done_sum",   out_sum,   exp_sum);
        check("done_co",    out_co,    exp_co);
        check("done_fa",    {fa_i0, fa_i1, fa_ci}, 0);
        held = out_sum;
        for (int s = 0; s < stall; s++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
                in_sub   = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            check("stall_valid",    out_valid, 1);
            check("stall_in_ready", in_ready,  0);
            check("stall_sum",      out_sum,   held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'($urandom);
        check_idle_outputs("release");
        check("release_sum_held", out_sum, exp_sum);
        check("release_co_held",  out_co,  exp_co);
        $display("op a=%02h b=%02h sub=%0d stall=%0d -> sum=%02h co=%0d (exp %02h/%0d)",
                 a, b, sub, stall, out_sum, out_co, exp_sum, exp_co);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_sum", out_sum, 0);
        check("reset_co",  out_co,  0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h5A, 8'h33, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h10, 8'h20, 1'b1, 0, 1'b0);
        do_op(8'h20, 8'h10, 1'b1, 0, 1'b0);
        do_op(8'hC3, 8'h7E, 1'b0, 5, 1'b1);
        do_op(8'h00, 8'h00, 1'b1, 0, 1'b0);

        // Asynchronous abort in the middle of RUN.
        out_ready = 1'b1;
        accept_cmd(8'h5A, 8'h33, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        check("abort_sum", out_sum, 0);
        check("abort_co",  out_co,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

        for (int n = 0; n < 100; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                  1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
